sub32_pipe: RTL

- Pipelined two's-complement subtractor, d = a - b - bin; the inverse-direction companion of the team's pipelined ripple adder.
- Operands are split into SEG-bit segments and resolved one segment per stage. The borrow ripples between stages, and operand/result bits are skewed through registers.
- Adds a valid/ready handshake with backpressure and status flags, so it can sit directly in the ALU datapath between the operand-fetch and writeback registers.

---
 rtl/sub32_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sub32_pipe.sv
// sub32_pipe: pipelined two's-complement subtractor, d = a - b - bin (mod 2^N).
// One SEG-bit segment is resolved per stage. The borrow ripples from stage to
// stage, and the operands still to be consumed travel alongside it.
// A valid/ready handshake with a global advance enable provides backpressure.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid, in_ready    input handshake (in_ready = !out_valid || out_ready)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid, out_ready  output handshake
//   d                     difference
//   bout                  borrow-out (unsigned a < b + bin)
//   zero                  d == 0
//   ovf                   signed overflow
module sub32_pipe #(
    parameter int unsigned N   = 32,
    parameter int unsigned SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    localparam int unsigned STAGES = N / SEG;

    logic              adv;

    // Per-stage state; index k holds pipeline stage k+1.
    logic [STAGES-1:0] v_q;
    logic [N-1:0]      res_q [STAGES];
    logic              brw_q [STAGES];
    // The final stage consumes no further operands, so it keeps none.
    logic [N-1:0]      opa_q [STAGES-1];
    logic [N-1:0]      opb_q [STAGES-1];
    logic              zero_q;
    logic              ovf_q;

    // Inputs to each stage's segment computation and the resulting next state.
    logic [N-1:0]      src_a  [STAGES];
    logic [N-1:0]      src_b  [STAGES];
    logic [N-1:0]      src_r  [STAGES];
    logic              src_br [STAGES];
    logic [N-1:0]      res_n  [STAGES];
    logic              brw_n  [STAGES];
    logic [SEG:0]      seg_t;
    logic              zero_n;
    logic              ovf_n;

    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    // Route the stage sources, then resolve one segment per stage.
    always_comb begin
        seg_t = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            src_a[k]  = '0;
            src_b[k]  = '0;
            src_r[k]  = '0;
            src_br[k] = 1'b0;
            res_n[k]  = '0;
            brw_n[k]  = 1'b0;
        end

        src_a[0]  = a;
        src_b[0]  = b;
        src_r[0]  = '0;
        src_br[0] = bin;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_a[k]  = opa_q[k-1];
            src_b[k]  = opb_q[k-1];
            src_r[k]  = res_q[k-1];
            src_br[k] = brw_q[k-1];
        end

        for (int k = 0; k < int'(STAGES); k++) begin
            // The extra top bit of the (SEG+1)-bit difference is the borrow.
            seg_t = {1'b0, src_a[k][k*SEG +: SEG]}
                  - {1'b0, src_b[k][k*SEG +: SEG]}
                  - (SEG+1)'(src_br[k]);
            res_n[k]                 = src_r[k];
            res_n[k][k*SEG +: SEG]   = seg_t[SEG-1:0];
            brw_n[k]                 = seg_t[SEG];
        end

        // Flags come from the full result as it enters the final stage.
        zero_n = (res_n[STAGES-1] == '0);
        ovf_n  = (src_a[STAGES-1][N-1] ^ src_b[STAGES-1][N-1])
               & (res_n[STAGES-1][N-1] ^ src_a[STAGES-1][N-1]);
    end

    // Stage registers: the whole pipe moves together or holds together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                res_q[k] <= '0;
                brw_q[k] <= 1'b0;
            end
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < int'(STAGES); k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < int'(STAGES); k++) begin
                res_q[k] <= res_n[k];
                brw_q[k] <= brw_n[k];
            end
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                opa_q[k] <= src_a[k];
                opb_q[k] <= src_b[k];
            end
            zero_q <= zero_n;
            ovf_q  <= ovf_n;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign d         = res_q[STAGES-1];
    assign bout      = brw_q[STAGES-1];
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule
